// File: rtl/regfile_dump_pkg.sv
// Shared types and constants for the register-file dump reader.
// Kept in a package so the reader and its bench agree on states and latency.
package regfile_dump_pkg;

  typedef enum logic [1:0] {
    DS_IDLE,
    DS_FETCH,
    DS_PRESENT
  } dump_state_t;

  // Cycles spent reading the register file before a beat is presented.
  localparam int DUMP_FETCH_LAT = 1;

endpackage

// File: rtl/regfile_dump_reader.sv
// Walks every register once the core halts and streams the contents out
// on a valid/ready channel, one beat per register address.
module regfile_dump_reader
  import regfile_dump_pkg::*;
#(
  parameter int W = 8,
  parameter int D = 4
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Done_in,
  input  logic         Zero_in,
  input  logic         DumpReq,
  output logic [D-1:0] Raddr,
  input  logic [W-1:0] RdData,
  output logic [W-1:0] DumpData,
  output logic [D-1:0] DumpAddr,
  output logic         DumpValid,
  input  logic         DumpReady,
  output logic         DumpLast,
  output logic         DumpZero,
  output logic         Busy
);

  localparam logic [D-1:0] LAST_ADDR = '1;

  dump_state_t  state_q;
  logic [D-1:0] raddr_q;
  logic [W-1:0] data_q;
  logic [D-1:0] addr_q;
  logic         valid_q;
  logic         last_q;
  logic         zero_q;
  logic         busy_q;
  logic         done_q;

  logic         trigger_d;
  logic [D-1:0] raddr_d;

  // A halt edge starts a dump; an explicit request only counts while halted.
  assign trigger_d = (Done_in & ~done_q) | (DumpReq & Done_in);
  assign raddr_d   = raddr_q + D'(1);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= DS_IDLE;
      raddr_q <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b1;
    end else begin
      done_q <= Done_in;
      case (state_q)
        DS_IDLE: begin
          if (trigger_d) begin
            raddr_q <= '0;
            busy_q  <= 1'b1;
            zero_q  <= Zero_in;
            state_q <= DS_FETCH;
          end
        end
        DS_FETCH: begin
          if (!Done_in) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            raddr_q <= '0;
            state_q <= DS_IDLE;
          end else begin
            data_q  <= RdData;
            addr_q  <= raddr_q;
            valid_q <= 1'b1;
            last_q  <= (raddr_q == LAST_ADDR);
            state_q <= DS_PRESENT;
          end
        end
        DS_PRESENT: begin
          // A restarted core wins over a handshake in the same cycle.
          if (!Done_in) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            raddr_q <= '0;
            state_q <= DS_IDLE;
          end else if (DumpReady) begin
            valid_q <= 1'b0;
            if (last_q) begin
              last_q  <= 1'b0;
              busy_q  <= 1'b0;
              raddr_q <= '0;
              state_q <= DS_IDLE;
            end else begin
              raddr_q <= raddr_d;
              state_q <= DS_FETCH;
            end
          end
        end
        default: begin
          valid_q <= 1'b0;
          last_q  <= 1'b0;
          busy_q  <= 1'b0;
          raddr_q <= '0;
          state_q <= DS_IDLE;
        end
      endcase
    end
  end

  assign Raddr     = raddr_q;
  assign DumpData  = data_q;
  assign DumpAddr  = addr_q;
  assign DumpValid = valid_q;
  assign DumpLast  = last_q;
  assign DumpZero  = zero_q;
  assign Busy      = busy_q;

endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
Read-side engine for the CPU register file. Once the machine halts (Done flag high), it walks every register address in turn and reads the register over a combinational read port. Each word leaves on a valid/ready stream to the testbench or debug harness. It captures final architectural state without pausing the core. It sits beside RegFile; the top level routes Raddr onto RaddrB while Busy is high.

Parameters:
W, 8, data path width (matches register width)
D, 4, address width; 2**D registers dumped per pass

Ports:
Clk  input  1  system clock
Reset  input  1  synchronous, active-high reset
Done_in  input  1  Done_out flag from register file (1 = halted)
Zero_in  input  1  Zero_out flag from register file
DumpReq  input  1  explicit dump request pulse
Raddr  output  D  register read address driven to register file
RdData  input  W  combinational read data for Raddr
DumpData  output  W  register contents of the current beat
DumpAddr  output  D  register index of the current beat
DumpValid  output  1  beat valid
DumpReady  input  1  sink accepts beat
DumpLast  output  1  marks the beat with DumpAddr == 2**D-1
DumpZero  output  1  Zero flag snapshot taken at trigger
Busy  output  1  dump in progress

Behaviour:
- Interface: one clock, Clk. Reset is synchronous and active-high, named Reset.
- Reset values:
  - state DS_IDLE.
  - Raddr, DumpData, DumpAddr = 0.
  - DumpValid, DumpLast, DumpZero, Busy = 0.
  - done_q = 1. This matches the register file's reset Done=1, so reset alone never triggers a dump.
- done_q is a registered copy of Done_in, updated every cycle.
- Trigger (DS_IDLE only): (Done_in & ~done_q) | (DumpReq & Done_in).
  - DumpReq while Done_in=0 is ignored.
  - DumpReq while Busy is ignored.
- On trigger:
  - Raddr <= 0, Busy <= 1, DumpZero <= Zero_in.
  - state DS_FETCH.
- DS_FETCH (exactly 1 cycle):
  - DumpData <= RdData, DumpAddr <= Raddr, DumpValid <= 1.
  - DumpLast <= (Raddr == 2**D-1).
  - state DS_PRESENT.
- DS_PRESENT:
  - While DumpValid & ~DumpReady: DumpData, DumpAddr, DumpLast and Raddr are held stable.
  - On DumpReady with DumpLast=0: DumpValid <= 0, Raddr <= Raddr+1, state DS_FETCH.
  - On DumpReady with DumpLast=1: DumpValid <= 0, DumpLast <= 0, Busy <= 0, Raddr <= 0, state DS_IDLE.
- Latency and throughput:
  - First DumpValid is high 2 cycles after the trigger edge.
  - Peak rate is one beat per 2 cycles.
  - Exactly 2**D beats per dump, addresses ascending 0..2**D-1.
  - Raddr never wraps past 2**D-1 within a dump.
- Abort: Done_in=0 in DS_FETCH or DS_PRESENT (core restarted) means:
  - next edge: DumpValid=0, DumpLast=0, Busy=0, Raddr=0, state DS_IDLE.
  - Abort beats a simultaneous DumpReady; that beat counts as not transferred.
- DumpZero holds its snapshot until the next trigger or Reset.
- Reset mid-dump: all outputs return to reset values at that edge. No partial beat is emitted afterwards.
- Arithmetic: Raddr is an unsigned D-bit increment only. No other datapath arithmetic.

Decomposition:
- Shared package regfile_dump_pkg:
  - typedef enum logic [1:0] {DS_IDLE, DS_FETCH, DS_PRESENT} dump_state_t.
  - constant DUMP_FETCH_LAT = 1.
- No sub-module is natural. The edge detect, counter and FSM form one module, about 150 lines.

Test Plan:
- Reset, then Done_in held 1 for 20 cycles -> DumpValid stays 0, Busy 0 (no spurious dump).
- Preload reg[i] = 3*i+1, Done_in 1->0->1, DumpReady=1 -> 16 beats:
  - DumpAddr 0..15, DumpData 1,4,...,46.
  - DumpLast only on addr 15.
  - First DumpValid 2 cycles after trigger, beats every 2 cycles, Busy falls after beat 15.
- Same preload, DumpReady low 5 cycles when DumpAddr=3 -> DumpData=10, DumpAddr=3, Raddr=3 stable throughout; beat 4 (data 13) follows the release.
- DumpReq pulse:
  - DumpReq with Done_in=1 while idle -> full 16-beat dump.
  - DumpReq with Done_in=0 -> no activity.
  - Second DumpReq at beat 6 -> ignored, still exactly 16 beats.
- Abort and reset:
  - Done_in dropped while DumpAddr=7 with DumpReady=1 -> next cycle DumpValid=0, Busy=0, Raddr=0, DS_IDLE.
  - Reset asserted at beat 5 -> all outputs at reset values next cycle.
- Zero_in=1 at trigger, toggled during dump -> DumpZero=1 for the whole dump; a new trigger with Zero_in=0 gives DumpZero=0.
